// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers,
// one-shot or auto-reload operation and a registered, maskable interrupt.
module timer_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      Addr,
   input  logic             WE,
   input  logic [CNT_W-1:0] Din,
   output logic [CNT_W-1:0] Dout,
   output logic             IRQ
);

   localparam int unsigned CTRL_W = 4;
   localparam logic [1:0]  OFS_CTRL   = 2'd0;
   localparam logic [1:0]  OFS_PRESET = 2'd1;
   localparam logic [1:0]  OFS_COUNT  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
   logic [CNT_W-1:0]    preset_q, preset_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                irq_flag_q, irq_flag_d;
   logic                irq_q, irq_d;

   logic                enable_c;
   logic [1:0]          mode_c;
   logic [1:0]          ofs_c;
   logic                unused_addr_c;

   assign enable_c      = ctrl_q[0];
   assign mode_c        = ctrl_q[2:1];
   assign ofs_c         = Addr[3:2];
   assign unused_addr_c = ^{Addr[31:4], Addr[1:0]};

   // Register file and FSM state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         irq_flag_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
         irq_q      <= irq_d;
      end
   end

   // Next-state logic; bus writes are applied last so they win over the FSM
   always_comb begin
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      irq_flag_d = irq_flag_q;

      case (state_q)
         ST_IDLE: begin
            if (enable_c) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!enable_c) begin
               state_d = ST_IDLE;
            end else if (count_q > CNT_W'(1)) begin
               count_d = count_q - CNT_W'(1);
            end else begin
               count_d    = '0;
               irq_flag_d = 1'b1;
               state_d    = ST_INT;
            end
         end
         ST_INT: begin
            if (mode_c == 2'd1) begin
               irq_flag_d = 1'b0;
               state_d    = ST_LOAD;
            end else begin
               ctrl_d[0] = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (WE) begin
         case (ofs_c)
            OFS_CTRL: begin
               ctrl_d     = Din[CTRL_W-1:0];
               irq_flag_d = 1'b0;
            end
            OFS_PRESET: begin
               preset_d = Din;
            end
            default: begin
            end
         endcase
      end
   end

   assign irq_d = ctrl_d[3] & irq_flag_d;
   assign IRQ   = irq_q;

   // Zero-latency register readback
   always_comb begin
      Dout = '0;
      case (ofs_c)
         OFS_CTRL:   Dout = CNT_W'(ctrl_q);
         OFS_PRESET: Dout = preset_q;
         OFS_COUNT:  Dout = count_q;
         default:    Dout = '0;
      endcase
   end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter: register access, one-shot,
// auto-reload, masking, disable, ignored writes and asynchronous reset.
module tb_timer_counter;

   logic        clk;
   logic        reset;
   logic [31:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;
   logic        clk_en;

   int n_tests;
   int n_fail;

   timer_counter #(.CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ)
   );

   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      Addr = a;
      Din  = d;
      WE   = 1'b1;
      @(posedge clk);
      #1;
      WE   = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      Addr = a;
      WE   = 1'b0;
      #1;
      d = Dout;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      for (int i = 0; i < 3; i++) begin
         rd(32'h7f00 + 32'(i * 4), v);
         n_tests++;
         if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_read[%0d] got=%h exp=0", i, v);
         end
      end
      n_tests++;
      if (IRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_irq got=%b exp=0", IRQ);
      end
      clk_en = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      cycle();
      for (int i = 0; i < 4; i++) begin
         rd(32'h7f00 + 32'(i * 4), v);
         n_tests++;
         if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL post_reset_read[%0d] got=%h exp=0", i, v);
         end
      end
   endtask

   task automatic test_mode0();
      logic [31:0] v;
      logic [31:0] exp_cnt [1:7];
      exp_cnt = '{32'd0, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
      wr(32'h7f04, 32'd5);
      wr(32'h7f00, 32'h9);
      for (int k = 1; k <= 7; k++) begin
         cycle();
         rd(32'h7f08, v);
         n_tests++;
         if (v !== exp_cnt[k]) begin
            n_fail++;
            $display("FAIL mode0_count k=%0d got=%0d exp=%0d", k, v, exp_cnt[k]);
         end
         n_tests++;
         if (IRQ !== (k == 7)) begin
            n_fail++;
            $display("FAIL mode0_irq k=%0d got=%b exp=%b", k, IRQ, (k == 7));
         end
      end
      cycle();
      rd(32'h7f00, v);
      n_tests++;
      if (v !== 32'h8) begin
         n_fail++;
         $display("FAIL mode0_ctrl got=%h exp=8", v);
      end
      cycle();
      cycle();
      n_tests++;
      if (IRQ !== 1'b1) begin
         n_fail++;
         $display("FAIL mode0_irq_hold got=%b exp=1", IRQ);
      end
      wr(32'h7f00, 32'h0);
      n_tests++;
      if (IRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL mode0_irq_clear got=%b exp=0", IRQ);
      end
   endtask

   task automatic test_mode1();
      logic [31:0] v;
      logic [31:0] ec;
      logic        ei;
      wr(32'h7f04, 32'd3);
      wr(32'h7f00, 32'hB);
      for (int k = 1; k <= 16; k++) begin
         cycle();
         case ((k - 2) % 5)
            0: ec = 32'd3;
            1: ec = 32'd2;
            2: ec = 32'd1;
            default: ec = 32'd0;
         endcase
         if (k < 2) ec = 32'd0;
         ei = (k >= 5) && ((k - 5) % 5 == 0);
         rd(32'h7f08, v);
         n_tests++;
         if (v !== ec) begin
            n_fail++;
            $display("FAIL mode1_count k=%0d got=%0d exp=%0d", k, v, ec);
         end
         n_tests++;
         if (IRQ !== ei) begin
            n_fail++;
            $display("FAIL mode1_irq k=%0d got=%b exp=%b", k, IRQ, ei);
         end
      end
      rd(32'h7f00, v);
      n_tests++;
      if (v !== 32'hB) begin
         n_fail++;
         $display("FAIL mode1_ctrl got=%h exp=b", v);
      end
      wr(32'h7f00, 32'h0);
      cycle();
   endtask

   task automatic test_mask();
      logic [31:0] v;
      wr(32'h7f04, 32'd2);
      wr(32'h7f00, 32'h1);
      for (int k = 1; k <= 6; k++) begin
         cycle();
         n_tests++;
         if (IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_irq k=%0d got=%b exp=0", k, IRQ);
         end
      end
      rd(32'h7f08, v);
      n_tests++;
      if (v !== 32'd0) begin
         n_fail++;
         $display("FAIL mask_count got=%0d exp=0", v);
      end
      rd(32'h7f00, v);
      n_tests++;
      if (v !== 32'h0) begin
         n_fail++;
         $display("FAIL mask_ctrl got=%h exp=0", v);
      end
      wr(32'h7f00, 32'h8);
      cycle();
      n_tests++;
      if (IRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL mask_unmask_irq got=%b exp=0", IRQ);
      end
      wr(32'h7f00, 32'h0);
   endtask

   task automatic test_disable();
      logic [31:0] v;
      wr(32'h7f04, 32'd10);
      wr(32'h7f00, 32'h1);
      for (int k = 0; k < 5; k++) cycle();
      rd(32'h7f08, v);
      n_tests++;
      if (v !== 32'd7) begin
         n_fail++;
         $display("FAIL disable_pre_count got=%0d exp=7", v);
      end
      wr(32'h7f00, 32'h0);
      for (int k = 0; k < 5; k++) begin
         rd(32'h7f08, v);
         n_tests++;
         if (v !== 32'd6 || IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_hold k=%0d got=%0d irq=%b exp=6 irq=0", k, v, IRQ);
         end
         cycle();
      end
      wr(32'h7f00, 32'h1);
      cycle();
      rd(32'h7f08, v);
      n_tests++;
      if (v !== 32'd6) begin
         n_fail++;
         $display("FAIL reenable_load got=%0d exp=6", v);
      end
      cycle();
      rd(32'h7f08, v);
      n_tests++;
      if (v !== 32'd10) begin
         n_fail++;
         $display("FAIL reenable_restart got=%0d exp=10", v);
      end
   endtask

   task automatic test_unmapped_and_reset();
      logic [31:0] v;
      cycle();
      wr(32'h7f08, 32'h1234);
      rd(32'h7f08, v);
      n_tests++;
      if (v !== 32'd8) begin
         n_fail++;
         $display("FAIL count_write_ignored got=%0d exp=8", v);
      end
      wr(32'h7f0c, 32'h1234);
      rd(32'h7f08, v);
      n_tests++;
      if (v !== 32'd7) begin
         n_fail++;
         $display("FAIL ofs_c_write_count got=%0d exp=7", v);
      end
      rd(32'h7f0c, v);
      n_tests++;
      if (v !== 32'h0) begin
         n_fail++;
         $display("FAIL ofs_c_read got=%h exp=0", v);
      end
      rd(32'h7f04, v);
      n_tests++;
      if (v !== 32'd10) begin
         n_fail++;
         $display("FAIL preset_intact got=%0d exp=10", v);
      end
      reset = 1'b0;
      rd(32'h7f08, v);
      n_tests++;
      if (v !== 32'd0) begin
         n_fail++;
         $display("FAIL async_reset_count got=%0d exp=0", v);
      end
      rd(32'h7f00, v);
      n_tests++;
      if (v !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset_ctrl got=%h exp=0", v);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      cycle();
   endtask

   task automatic test_preset_zero();
      wr(32'h7f04, 32'd0);
      wr(32'h7f00, 32'h9);
      for (int k = 1; k <= 3; k++) begin
         cycle();
         n_tests++;
         if (IRQ !== (k == 3)) begin
            n_fail++;
            $display("FAIL preset0_irq k=%0d got=%b exp=%b", k, IRQ, (k == 3));
         end
      end
      wr(32'h7f00, 32'h0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      wr(32'h7f04, 32'd4);
      wr(32'h7f00, 32'hB);
      cycle();
      cycle();
      rd(32'h7f08, v);
      n_tests++;
      if (v !== 32'd4) begin
         n_fail++;
         $display("FAIL b2b_load got=%0d exp=4", v);
      end
      wr(32'h7f04, 32'd2);
      rd(32'h7f08, v);
      n_tests++;
      if (v !== 32'd3) begin
         n_fail++;
         $display("FAIL b2b_preset_mid_count got=%0d exp=3", v);
      end
      cycle();
      cycle();
      cycle();
      n_tests++;
      if (IRQ !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_irq_first got=%b exp=1", IRQ);
      end
      cycle();
      n_tests++;
      if (IRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_irq_pulse_end got=%b exp=0", IRQ);
      end
      cycle();
      rd(32'h7f08, v);
      n_tests++;
      if (v !== 32'd2) begin
         n_fail++;
         $display("FAIL b2b_new_preset got=%0d exp=2", v);
      end
      cycle();
      cycle();
      n_tests++;
      if (IRQ !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_irq_second got=%b exp=1", IRQ);
      end
      wr(32'h7f00, 32'h8);
      n_tests++;
      if (IRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_write_in_int_irq got=%b exp=0", IRQ);
      end
      rd(32'h7f00, v);
      n_tests++;
      if (v !== 32'h8) begin
         n_fail++;
         $display("FAIL b2b_write_in_int_ctrl got=%h exp=8", v);
      end
      cycle();
      cycle();
   endtask

   task automatic test_irq_async_reset();
      wr(32'h7f04, 32'd1);
      wr(32'h7f00, 32'h9);
      for (int k = 0; k < 4; k++) cycle();
      n_tests++;
      if (IRQ !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_before_reset got=%b exp=1", IRQ);
      end
      #2;
      reset = 1'b0;
      #1;
      n_tests++;
      if (IRQ !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_irq got=%b exp=0", IRQ);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      cycle();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      clk_en  = 1'b0;
      reset   = 1'b0;
      Addr    = 32'h7f00;
      WE      = 1'b0;
      Din     = 32'h0;
      #20;
      test_reset();
      test_mode0();
      test_mode1();
      test_mask();
      test_disable();
      test_unmapped_and_reset();
      test_preset_zero();
      test_back_to_back();
      test_irq_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped timer that consumes the TC0/TC1 port group driven by the system bridge: Addr, WE, Din in, Dout back.
- Two instances are used: TC0 at 0x7f00–0x7f0b and TC1 at 0x7f10–0x7f1b.
- Each instance holds CTRL, PRESET and COUNT registers, counts down from PRESET, and raises an interrupt line toward the CPU's external-interrupt inputs.
- Supports one-shot mode (mode 0) and auto-reload mode (mode 1).

Parameters:
- CNT_W, 32, width of PRESET and COUNT registers and of Din/Dout.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (low = reset asserted), applied immediately, released synchronously to clk by upstream logic.
- Addr  input  32  byte address from bridge; only Addr[3:2] decoded (0=CTRL, 1=PRESET, 2=COUNT, 3=unmapped).
- WE  input  1  write enable, already qualified by bridge (in range and word-wide).
- Din  input  CNT_W  write data.
- Dout  output  CNT_W  read data, combinational from registers.
- IRQ  output  1  interrupt request, registered.

Behaviour:
- CTRL fields: bit0 = Enable, bits[2:1] = Mode, bit3 = IM (interrupt mask, 1 = allow). Bits[31:4] are not stored and read 0.
- Reset values:
  - CTRL = 0, PRESET = 0, COUNT = 0.
  - state = IDLE, irq_flag = 0.
  - IRQ = 0, Dout = 0 (address 0 reads CTRL = 0).
- Reads (no latency, no side effects):
  - Dout = {28'b0, CTRL[3:0]} / PRESET / COUNT by Addr[3:2].
  - Addr[3:2] = 3 reads 0.
- Writes (take effect at the edge where WE = 1):
  - CTRL <= Din[3:0] and clears irq_flag.
  - PRESET <= Din.
  - Writes to COUNT and to offset 0xc are ignored.
- FSM (uses the registered CTRL value of the current cycle):
  - IDLE: Enable = 1 -> LOAD; else stay.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT:
    - Enable = 0 -> IDLE; COUNT holds.
    - Else if COUNT > 1: COUNT <= COUNT - 1.
    - Else: COUNT <= 0, irq_flag <= 1, -> INT.
  - INT, Mode = 1: irq_flag <= 0, -> LOAD (reload).
  - INT, Mode = 0/2/3: Enable <= 0, irq_flag held, -> IDLE.
- IRQ is registered: IRQ <= IM & irq_flag_next.
  - Mode 1 gives exactly a one-cycle pulse, high during the INT cycle.
  - Mode 0 holds IRQ high until a CTRL write clears irq_flag or IM.
- Latency: Enable write at edge t → LOAD after t+1, COUNT = PRESET after t+2, INT and IRQ high after edge t+PRESET+2 (PRESET ≥ 1).
- PRESET = 0 or 1: LOAD → CNT → INT, i.e. IRQ after t+3.
- Simultaneous events:
  - A CTRL write in the same cycle as the INT Enable-clear: the written value wins.
  - A CTRL write in INT: irq_flag clears, and the write wins over the FSM flag set/clear.
  - A PRESET write during CNT does not disturb COUNT; it is used at the next LOAD.
  - A COUNT write in any state is ignored.
- Mid-count disable: Enable = 0 freezes COUNT and returns to IDLE next edge. Re-enable goes through LOAD (COUNT restarts from PRESET, no resume).
- Reset asserted mid-operation: all registers return to reset values immediately. IRQ drops without waiting for clk.
- COUNT never wraps below 0.

Test Plan:
- Reset (low) with clk idle: Dout = 0 at Addr 0x0/0x4/0x8, IRQ = 0. Release reset; all registers read 0.
- Mode 0: write PRESET = 5, then CTRL = 0x9.
  - COUNT reads 5,4,3,2,1,0 on successive cycles.
  - IRQ rises exactly 7 edges after the CTRL write and stays high.
  - CTRL reads 0x8.
  - Writing CTRL = 0 drops IRQ next edge.
- Mode 1: PRESET = 3, CTRL = 0xB.
  - IRQ is a one-cycle pulse repeating every 5 cycles (COUNT 3,2,1,0, LOAD).
  - Enable stays 1.
- Mask: PRESET = 2, CTRL = 0x1.
  - COUNT reaches 0 and IRQ stays 0.
  - Then writing CTRL = 0x8 with flag cleared keeps IRQ 0.
- Disable mid-count: PRESET = 10, CTRL = 0x1, then CTRL = 0x0 after COUNT = 6. COUNT stays 6 and no IRQ.
  - Writing CTRL = 0x1 again: COUNT reads 10 two edges later.
- Unmapped/COUNT writes and async reset: write 0x1234 to Addr 0x8 and 0xc → COUNT unchanged, 0xc reads 0.
  - Assert reset mid-count → IRQ and COUNT = 0 before next clk edge.
